// File: rtl/lock_pkg.sv
// Shared state encoding and digit-slice helper for the sequential combination lock.
package lock_pkg;

    typedef enum logic [1:0] {
        StLocked = 2'd0,
        StOpen   = 2'd1,
        StAlarm  = 2'd2,
        StProg   = 2'd3
    } lock_state_e;

    // Bit offset of digit idx inside a packed code; digit 0 sits in the MSBs.
    function automatic int unsigned digit_lsb(input int unsigned idx,
                                              input int unsigned digit_w,
                                              input int unsigned code_len);
        return (code_len - 1 - idx) * digit_w;
    endfunction

endpackage

// File: rtl/seq_lock_if.sv
// Keypad-side/actuator-side signal bundle of seq_lock; prog_req exists only with LOCK_PROG_EN.
interface seq_lock_if #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned CODE_LEN  = 4,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
    localparam int unsigned FailW = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               clear;
`ifdef LOCK_PROG_EN
    logic               prog_req;
`endif
    logic               unlock;
    logic               buzzer;
    logic [CntW-1:0]    count;
    logic [FailW-1:0]   fails;
    logic [1:0]         state;

`ifdef LOCK_PROG_EN
    modport master (output digit_in, digit_valid, clear, prog_req,
                    input  unlock, buzzer, count, fails, state);
    modport slave  (input  digit_in, digit_valid, clear, prog_req,
                    output unlock, buzzer, count, fails, state);
`else
    modport master (output digit_in, digit_valid, clear,
                    input  unlock, buzzer, count, fails, state);
    modport slave  (input  digit_in, digit_valid, clear,
                    output unlock, buzzer, count, fails, state);
`endif

endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter timing the buzzer lockout; done is high while the count is zero.
module lockout_timer #(
    parameter int unsigned LOCKOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int unsigned TimW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [TimW-1:0] LoadVal = TimW'(LOCKOUT_CYC - 1);

    logic [TimW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/seq_lock.sv
// Sequential combination lock: digit compare, fail counting, timed lockout.
// Build with LOCK_PROG_EN to make the code reprogrammable from the OPEN state.
module seq_lock
    import lock_pkg::*;
#(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned CODE_LEN    = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'hBFDC
) (
    input logic       clk,
    input logic       reset,
    seq_lock_if.slave bus
);
    localparam int unsigned CodeW = DIGIT_W * CODE_LEN;
    localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
    localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
    localparam logic [CntW-1:0]  LastIdx = CntW'(CODE_LEN - 1);
    localparam logic [FailW-1:0] FailMax = FailW'(MAX_TRIES);

    lock_state_e      state_q;
    logic             unlock_q, buzzer_q, mis_q;
    logic [CntW-1:0]  count_q;
    logic [FailW-1:0] fails_q;
    logic [CodeW-1:0] code_cur;

    logic             digit_hit, last_digit, mis_all, lock_done, alarm_enter, timer_done;
    logic [FailW-1:0] fails_nxt;
    logic [DIGIT_W-1:0] ref_digit;

    assign ref_digit   = code_cur[digit_lsb(int'(count_q), DIGIT_W, CODE_LEN) +: DIGIT_W];
    // clear always wins over a simultaneous strobe
    assign digit_hit   = bus.digit_valid && !bus.clear;
    assign last_digit  = (count_q == LastIdx);
    assign mis_all     = mis_q | (bus.digit_in != ref_digit);
    assign fails_nxt   = fails_q + 1'b1;
    assign lock_done   = (state_q == StLocked) && digit_hit && last_digit;
    assign alarm_enter = lock_done && mis_all && (fails_nxt >= FailMax);

`ifdef LOCK_PROG_EN
    logic [CodeW-1:0] code_q, shadow_q, shadow_d;

    // Writes land in the shadow; the live code only changes when all digits are in.
    always_comb begin
        shadow_d = (state_q == StOpen) ? code_q : shadow_q;
        if ((state_q == StProg) && digit_hit) begin
            shadow_d[digit_lsb(int'(count_q), DIGIT_W, CODE_LEN) +: DIGIT_W] = bus.digit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q   <= DEFAULT_CODE;
            shadow_q <= DEFAULT_CODE;
        end else begin
            shadow_q <= shadow_d;
            if ((state_q == StProg) && digit_hit && last_digit) begin
                code_q <= shadow_d;
            end
        end
    end

    assign code_cur = code_q;
`else
    assign code_cur = DEFAULT_CODE;
`endif

    lockout_timer #(
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) u_lockout_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (alarm_enter),
        .dec_i  (state_q == StAlarm),
        .done_o (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StLocked;
            unlock_q <= 1'b0;
            buzzer_q <= 1'b0;
            count_q  <= '0;
            fails_q  <= '0;
            mis_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StLocked: begin
                    if (bus.clear) begin
                        count_q <= '0;
                        mis_q   <= 1'b0;
                    end else if (bus.digit_valid) begin
                        if (last_digit) begin
                            count_q <= '0;
                            mis_q   <= 1'b0;
                            if (!mis_all) begin
                                state_q  <= StOpen;
                                unlock_q <= 1'b1;
                                fails_q  <= '0;
                            end else if (alarm_enter) begin
                                state_q  <= StAlarm;
                                buzzer_q <= 1'b1;
                                fails_q  <= FailMax;
                            end else begin
                                fails_q <= fails_nxt;
                            end
                        end else begin
                            count_q <= count_q + 1'b1;
                            mis_q   <= mis_all;
                        end
                    end
                end
                StOpen: begin
                    if (bus.clear) begin
                        state_q  <= StLocked;
                        unlock_q <= 1'b0;
                        count_q  <= '0;
`ifdef LOCK_PROG_EN
                    end else if (bus.prog_req) begin
                        state_q  <= StProg;
                        unlock_q <= 1'b0;
                        count_q  <= '0;
`endif
                    end
                end
                StAlarm: begin
                    if (timer_done) begin
                        state_q  <= StLocked;
                        buzzer_q <= 1'b0;
                        fails_q  <= '0;
                    end
                end
`ifdef LOCK_PROG_EN
                StProg: begin
                    if (bus.clear) begin
                        state_q  <= StOpen;
                        unlock_q <= 1'b1;
                        count_q  <= '0;
                    end else if (bus.digit_valid) begin
                        if (last_digit) begin
                            state_q <= StLocked;
                            count_q <= '0;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= StLocked;
                end
            endcase
        end
    end

    assign bus.unlock = unlock_q;
    assign bus.buzzer = buzzer_q;
    assign bus.count  = count_q;
    assign bus.fails  = fails_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_seq_lock.sv
// Randomised self-checking bench for seq_lock against a queue-based behavioural model.
module tb_seq_lock;
    localparam int DW = 4;
    localparam int CL = 4;
    localparam int MT = 3;
    localparam int LC = 16;
    localparam logic [15:0] DEF_CODE = 16'hBFDC;
`ifdef LOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic clk, reset;
    int   checks, errors;

    seq_lock_if #(.DIGIT_W(DW), .CODE_LEN(CL), .MAX_TRIES(MT)) bus ();

    seq_lock #(
        .DIGIT_W(DW), .CODE_LEN(CL), .MAX_TRIES(MT), .LOCKOUT_CYC(LC), .DEFAULT_CODE(DEF_CODE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: 0 locked, 1 open, 2 alarm, 3 prog
    int m_state, m_fails, m_left;
    int m_entry[$];
    int m_prog[$];
    int m_code[CL];

    function automatic void model_step(input bit rst, input bit dv, input int d,
                                       input bit clr, input bit prq);
        bit match;
        if (rst) begin
            m_state = 0; m_fails = 0; m_left = 0;
            m_entry.delete(); m_prog.delete();
            for (int i = 0; i < CL; i++) m_code[i] = int'((DEF_CODE >> ((CL - 1 - i) * DW)) & 16'hF);
            return;
        end
        case (m_state)
            0: if (clr) m_entry.delete();
               else if (dv) begin
                   m_entry.push_back(d);
                   if (m_entry.size() == CL) begin
                       match = 1'b1;
                       for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) match = 1'b0;
                       m_entry.delete();
                       if (match) begin m_state = 1; m_fails = 0; end
                       else if (m_fails + 1 < MT) m_fails++;
                       else begin m_fails = MT; m_state = 2; m_left = LC; end
                   end
               end
            1: if (clr) m_state = 0;
               else if (prq && PROG_EN) begin m_state = 3; m_prog.delete(); end
            2: begin
                   m_left--;
                   if (m_left == 0) begin m_state = 0; m_fails = 0; end
               end
            default: if (clr) begin m_state = 1; m_prog.delete(); end
               else if (dv) begin
                   m_prog.push_back(d);
                   if (m_prog.size() == CL) begin
                       for (int i = 0; i < CL; i++) m_code[i] = m_prog[i];
                       m_prog.delete();
                       m_state = 0;
                   end
               end
        endcase
    endfunction

    function automatic logic [8:0] exp_vec();
        int c;
        c = (m_state == 3) ? m_prog.size() : m_entry.size();
        return {2'(m_state), m_state == 1, m_state == 2, 3'(c), 2'(m_fails)};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {bus.state, bus.unlock, bus.buzzer, bus.count, bus.fails};
    endfunction

    task automatic drive(input bit dv, input int d, input bit clr, input bit prq);
        @(negedge clk);
        reset = 1'b0;
        bus.digit_valid = dv;
        bus.digit_in = 4'(d);
        bus.clear = clr;
`ifdef LOCK_PROG_EN
        bus.prog_req = prq;
`endif
        @(posedge clk);
        model_step(1'b0, dv, d, clr, prq);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.digit_valid = 1'b0;
        bus.clear = 1'b0;
`ifdef LOCK_PROG_EN
        bus.prog_req = 1'b0;
`endif
        @(posedge clk);
        model_step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== 9'h000) begin
            errors++; $display("FAIL reset_state got %h want %h", obs_vec(), 9'h000);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_correct();
        int digs[4] = '{11, 15, 13, 12};
        for (int i = 0; i < CL; i++) begin
            drive(1'b1, digs[i], 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL correct_digit%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.unlock !== 1'b1 || bus.count !== 3'd0 || bus.fails !== 2'd0) begin
            errors++; $display("FAIL correct_open got u=%b c=%0d f=%0d want u=1 c=0 f=0",
                               bus.unlock, bus.count, bus.fails);
        end
        drive(1'b1, 3, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL open_ignores_digit got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL open_relock got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_wrong_digit();
        enter(11, 1, 10, 13);
        checks++;
        if (obs_vec() !== exp_vec() || bus.fails !== 2'd1) begin
            errors++; $display("FAIL wrong_fails got %h want %h", obs_vec(), exp_vec());
        end
        enter(11, 15, 13, 12);
        checks++;
        if (obs_vec() !== exp_vec() || bus.unlock !== 1'b1) begin
            errors++; $display("FAIL wrong_then_open got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_lockout();
        int buzz, digs[4] = '{11, 15, 13, 12};
        enter(0, 15, 13, 12);
        enter(11, 1, 10, 13);
        enter(11, 15, 13, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL lockout_enter got %h want %h", obs_vec(), exp_vec());
        end
        buzz = int'(bus.buzzer);
        for (int i = 0; i < LC + 3; i++) begin
            drive(i < LC - 1, digs[i % 4], ($urandom_range(0, 3) == 0), 1'b0);
            buzz += int'(bus.buzzer);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL lockout_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (buzz !== LC) begin
            errors++; $display("FAIL buzzer_len got %0d want %0d", buzz, LC);
        end
        checks++;
        if (bus.state !== 2'd0 || bus.fails !== 2'd0) begin
            errors++; $display("FAIL after_alarm got s=%0d f=%0d want s=0 f=0", bus.state, bus.fails);
        end
    endtask

    task automatic test_abort();
        enter(1, 2, 3, 4);
        drive(1'b1, 11, 1'b0, 1'b0);
        drive(1'b1, 15, 1'b0, 1'b0);
        drive(1'b1, 13, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.count !== 3'd0 || bus.fails !== 2'd1) begin
            errors++; $display("FAIL abort_clear got %h want %h", obs_vec(), exp_vec());
        end
        enter(11, 15, 13, 12);
        checks++;
        if (obs_vec() !== exp_vec() || bus.unlock !== 1'b1) begin
            errors++; $display("FAIL abort_then_open got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 11, 1'b0, 1'b0);
        drive(1'b1, 15, 1'b0, 1'b0);
        do_reset();
        checks++;
        if (obs_vec() !== 9'h000) begin
            errors++; $display("FAIL reset_mid_entry got %h want %h", obs_vec(), 9'h000);
        end
        for (int i = 0; i < MT; i++) enter(1, 1, 1, 1);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        do_reset();
        checks++;
        if (obs_vec() !== 9'h000) begin
            errors++; $display("FAIL reset_mid_alarm got %h want %h", obs_vec(), 9'h000);
        end
        // Timer must have been cleared too: a fresh lockout lasts the full duration.
        for (int i = 0; i < MT; i++) enter(2, 2, 2, 2);
        for (int i = 0; i < LC + 1; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL realarm_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef LOCK_PROG_EN
    task automatic test_prog();
        do_reset();
        enter(11, 15, 13, 12);
        drive(1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (bus.state !== 2'd3 || bus.unlock !== 1'b0) begin
            errors++; $display("FAIL prog_enter got s=%0d u=%b want s=3 u=0", bus.state, bus.unlock);
        end
        enter(1, 2, 3, 4);
        checks++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd0) begin
            errors++; $display("FAIL prog_done got %h want %h", obs_vec(), exp_vec());
        end
        enter(11, 15, 13, 12);
        checks++;
        if (bus.unlock !== 1'b0 || bus.fails !== 2'd1) begin
            errors++; $display("FAIL old_code_rejected got u=%b f=%0d want u=0 f=1", bus.unlock, bus.fails);
        end
        enter(1, 2, 3, 4);
        checks++;
        if (bus.unlock !== 1'b1) begin
            errors++; $display("FAIL new_code_opens got u=%b want u=1", bus.unlock);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        drive(1'b1, 9, 1'b0, 1'b0);
        drive(1'b1, 9, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.unlock !== 1'b1) begin
            errors++; $display("FAIL prog_abort got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        enter(1, 2, 3, 4);
        checks++;
        if (bus.unlock !== 1'b1) begin
            errors++; $display("FAIL code_kept got u=%b want u=1", bus.unlock);
        end
    endtask
`endif

    task automatic test_random();
        bit dv, clr, prq;
        int d;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                dv  = ($urandom_range(0, 1) == 1);
                clr = ($urandom_range(0, 15) == 0);
                prq = ($urandom_range(0, 3) == 0);
                if (m_state == 0 && $urandom_range(0, 3) != 0) d = m_code[m_entry.size()];
                else d = int'($urandom_range(0, 15));
                drive(dv, d, clr, prq);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.digit_in = '0;
        bus.digit_valid = 1'b0;
        bus.clear = 1'b0;
`ifdef LOCK_PROG_EN
        bus.prog_req = 1'b0;
`endif
        model_step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        test_reset();
        test_correct();
        test_wrong_digit();
        test_lockout();
        test_abort();
        test_reset_mid();
`ifdef LOCK_PROG_EN
        test_prog();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
